// File: rtl/memory_stage.sv
// Memory-access stage: data-cache req/ack port, byte lanes, load extend,
// writeback pipeline register and the upstream memory stall.
// Ports:
//   i_clk, i_arst       : clock, async active-high reset
//   i_alu_result ...    : execute-stage bundle (address, data, func3, ctl)
//   o_dc_* / i_dc_*     : data-cache request/ack port
//   o_stall_mem         : freezes upstream stages while an access is open
//   o_read_data ...     : registered writeback bundle
// Option: define MISALIGN_TRAP_EN to trap misaligned accesses
//   (cause 4 on loads, 6 on stores); otherwise offsets are force-aligned.
module memory_stage #(
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64,
  parameter int REG_ADDR_W = 5,
  localparam int NB = DATA_WIDTH / 8
) (
  input  logic                  i_clk,
  input  logic                  i_arst,
  input  logic [ADDR_WIDTH-1:0] i_alu_result,
  input  logic [DATA_WIDTH-1:0] i_write_data,
  input  logic [2:0]            i_func3,
  input  logic                  i_mem_access,
  input  logic                  i_mem_we,
  input  logic                  i_reg_we,
  input  logic [2:0]            i_result_src,
  input  logic [REG_ADDR_W-1:0] i_rd_addr,
  input  logic [ADDR_WIDTH-1:0] i_pc_plus4,
  input  logic [3:0]            i_cause,
  output logic                  o_dc_req,
  output logic                  o_dc_we,
  output logic [ADDR_WIDTH-1:0] o_dc_addr,
  output logic [DATA_WIDTH-1:0] o_dc_wdata,
  output logic [NB-1:0]         o_dc_wstrb,
  input  logic                  i_dc_ack,
  input  logic [DATA_WIDTH-1:0] i_dc_rdata,
  output logic                  o_stall_mem,
  output logic [DATA_WIDTH-1:0] o_read_data,
  output logic [ADDR_WIDTH-1:0] o_alu_result,
  output logic [REG_ADDR_W-1:0] o_rd_addr,
  output logic                  o_reg_we,
  output logic [2:0]            o_result_src,
  output logic [ADDR_WIDTH-1:0] o_pc_plus4,
  output logic [3:0]            o_cause
);

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  state_t state_q, state_d;

  logic [2:0]            off;
  logic [2:0]            off_a;
  logic [1:0]            sz;
  logic                  illegal;
  logic                  misal;
  logic                  access_ok;
  logic [NB-1:0]         strb_base;
  logic [DATA_WIDTH-1:0] rd_sh;
  logic [DATA_WIDTH-1:0] ld_ext;
  logic [3:0]            cause_d;
  logic                  reg_we_d;
  logic [DATA_WIDTH-1:0] rdata_d;

  assign off = i_alu_result[2:0];
  assign sz  = i_func3[1:0];

  // Stores only have sb/sh/sw/sd; loads lack an unsigned doubleword.
  assign illegal = i_mem_access &
                   (i_mem_we ? i_func3[2]
                             : (i_func3 == 3'd7));

`ifdef MISALIGN_TRAP_EN
  always_comb begin
    misal = 1'b0;
    unique case (sz)
      2'd1:    misal = off[0];
      2'd2:    misal = |off[1:0];
      2'd3:    misal = |off;
      default: misal = 1'b0;
    endcase
    misal = misal & i_mem_access & ~illegal;
  end
`else
  assign misal = 1'b0;
`endif

  assign access_ok = i_mem_access &
                     (i_cause == 4'd0) &
                     ~illegal & ~misal;

  // Offset bits below the access size are dropped (natural alignment).
  always_comb begin
    off_a     = off;
    strb_base = NB'(8'h01);
    unique case (sz)
      2'd0: begin
        off_a     = off;
        strb_base = NB'(8'h01);
      end
      2'd1: begin
        off_a     = {off[2:1], 1'b0};
        strb_base = NB'(8'h03);
      end
      2'd2: begin
        off_a     = {off[2], 2'b00};
        strb_base = NB'(8'h0F);
      end
      default: begin
        off_a     = 3'd0;
        strb_base = NB'(8'hFF);
      end
    endcase
  end

  assign o_dc_addr  = {i_alu_result[ADDR_WIDTH-1:3], 3'b000};
  assign o_dc_wdata = i_write_data << {off_a, 3'b000};
  assign o_dc_wstrb = i_mem_we ? (strb_base << off_a) : '0;

  assign rd_sh = i_dc_rdata >> {off_a, 3'b000};

  always_comb begin
    ld_ext = rd_sh;
    unique case (i_func3)
      3'd0: ld_ext = {{(DATA_WIDTH-8){rd_sh[7]}},
                      rd_sh[7:0]};
      3'd1: ld_ext = {{(DATA_WIDTH-16){rd_sh[15]}},
                      rd_sh[15:0]};
      3'd2: ld_ext = {{(DATA_WIDTH-32){rd_sh[31]}},
                      rd_sh[31:0]};
      3'd4: ld_ext = {{(DATA_WIDTH-8){1'b0}},
                      rd_sh[7:0]};
      3'd5: ld_ext = {{(DATA_WIDTH-16){1'b0}},
                      rd_sh[15:0]};
      3'd6: ld_ext = {{(DATA_WIDTH-32){1'b0}},
                      rd_sh[31:0]};
      default: ld_ext = rd_sh;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (access_ok & ~i_dc_ack) state_d = WAIT;
      WAIT: if (i_dc_ack)              state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Reset gates the request directly so it drops without a clock.
  assign o_dc_req = ~i_arst &
                    ((state_q == WAIT) | access_ok);
  assign o_dc_we     = o_dc_req & i_mem_we;
  assign o_stall_mem = o_dc_req & ~i_dc_ack;

  always_comb begin
    cause_d = 4'd0;
    if (i_cause != 4'd0) cause_d = i_cause;
    else if (illegal)    cause_d = 4'd2;
    else if (misal)      cause_d = i_mem_we ? 4'd6 : 4'd4;
  end

  assign reg_we_d = i_reg_we & (cause_d == 4'd0);
  assign rdata_d  = (access_ok & ~i_mem_we) ? ld_ext : '0;

  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) begin
      o_read_data  <= '0;
      o_alu_result <= '0;
      o_rd_addr    <= '0;
      o_reg_we     <= 1'b0;
      o_result_src <= '0;
      o_pc_plus4   <= '0;
      o_cause      <= '0;
    end else if (o_stall_mem) begin
      o_read_data  <= '0;
      o_alu_result <= '0;
      o_rd_addr    <= '0;
      o_reg_we     <= 1'b0;
      o_result_src <= '0;
      o_pc_plus4   <= '0;
      o_cause      <= '0;
    end else begin
      o_read_data  <= rdata_d;
      o_alu_result <= i_alu_result;
      o_rd_addr    <= i_rd_addr;
      o_reg_we     <= reg_we_d;
      o_result_src <= i_result_src;
      o_pc_plus4   <= i_pc_plus4;
      o_cause      <= cause_d;
    end
  end

endmodule

// File: tb/tb_memory_stage.sv
// Directed self-checking bench for memory_stage.
// Covers pass-through, stalls, extend, lanes, traps and reset.
module tb_memory_stage;

  logic        i_clk;
  logic        i_arst;
  logic [63:0] i_alu_result;
  logic [63:0] i_write_data;
  logic [2:0]  i_func3;
  logic        i_mem_access;
  logic        i_mem_we;
  logic        i_reg_we;
  logic [2:0]  i_result_src;
  logic [4:0]  i_rd_addr;
  logic [63:0] i_pc_plus4;
  logic [3:0]  i_cause;
  logic        o_dc_req;
  logic        o_dc_we;
  logic [63:0] o_dc_addr;
  logic [63:0] o_dc_wdata;
  logic [7:0]  o_dc_wstrb;
  logic        i_dc_ack;
  logic [63:0] i_dc_rdata;
  logic        o_stall_mem;
  logic [63:0] o_read_data;
  logic [63:0] o_alu_result;
  logic [4:0]  o_rd_addr;
  logic        o_reg_we;
  logic [2:0]  o_result_src;
  logic [63:0] o_pc_plus4;
  logic [3:0]  o_cause;

  int n_vec;
  int n_err;

  memory_stage dut (
    .i_clk        (i_clk),
    .i_arst       (i_arst),
    .i_alu_result (i_alu_result),
    .i_write_data (i_write_data),
    .i_func3      (i_func3),
    .i_mem_access (i_mem_access),
    .i_mem_we     (i_mem_we),
    .i_reg_we     (i_reg_we),
    .i_result_src (i_result_src),
    .i_rd_addr    (i_rd_addr),
    .i_pc_plus4   (i_pc_plus4),
    .i_cause      (i_cause),
    .o_dc_req     (o_dc_req),
    .o_dc_we      (o_dc_we),
    .o_dc_addr    (o_dc_addr),
    .o_dc_wdata   (o_dc_wdata),
    .o_dc_wstrb   (o_dc_wstrb),
    .i_dc_ack     (i_dc_ack),
    .i_dc_rdata   (i_dc_rdata),
    .o_stall_mem  (o_stall_mem),
    .o_read_data  (o_read_data),
    .o_alu_result (o_alu_result),
    .o_rd_addr    (o_rd_addr),
    .o_reg_we     (o_reg_we),
    .o_result_src (o_result_src),
    .o_pc_plus4   (o_pc_plus4),
    .o_cause      (o_cause)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%h want 0x%h",
               tag, got, exp);
    end
  endtask

  task automatic cyc;
    @(posedge i_clk);
    #1;
  endtask

  task automatic mem(input logic [63:0] a,
                     input logic [2:0]  f3,
                     input logic        we,
                     input logic [63:0] wd);
    i_alu_result = a;
    i_func3      = f3;
    i_mem_access = 1'b1;
    i_mem_we     = we;
    i_reg_we     = ~we;
    i_write_data = wd;
    i_rd_addr    = 5'd10;
    i_result_src = 3'd1;
    i_pc_plus4   = 64'h200;
    i_cause      = 4'd0;
  endtask

  task automatic idle_in;
    i_mem_access = 1'b0;
    i_mem_we     = 1'b0;
    i_dc_ack     = 1'b0;
    i_cause      = 4'd0;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    i_arst       = 1'b1;
    i_alu_result = '0;
    i_write_data = '0;
    i_func3      = '0;
    i_mem_access = 1'b0;
    i_mem_we     = 1'b0;
    i_reg_we     = 1'b0;
    i_result_src = '0;
    i_rd_addr    = '0;
    i_pc_plus4   = '0;
    i_cause      = '0;
    i_dc_ack     = 1'b0;
    i_dc_rdata   = '0;
    #2;
    chk("rst_req", o_dc_req, 0);
    chk("rst_rdata", o_read_data, 0);
    chk("rst_regwe", o_reg_we, 0);
    chk("rst_cause", o_cause, 0);
    cyc;
    i_arst = 1'b0;

    // add: pure pass-through
    i_alu_result = 64'h1234;
    i_rd_addr    = 5'd7;
    i_reg_we     = 1'b1;
    i_result_src = 3'd0;
    i_pc_plus4   = 64'h104;
    #2;
    chk("add_stall", o_stall_mem, 0);
    chk("add_req", o_dc_req, 0);
    cyc;
    chk("add_alu", o_alu_result, 64'h1234);
    chk("add_rd", o_rd_addr, 7);
    chk("add_we", o_reg_we, 1);
    chk("add_pc4", o_pc_plus4, 64'h104);

    // ld 0x1000, ack after three stall cycles
    mem(64'h1000, 3'd3, 1'b0, 64'h0);
    #2;
    chk("ld_req", o_dc_req, 1);
    chk("ld_addr", o_dc_addr, 64'h1000);
    chk("ld_stall0", o_stall_mem, 1);
    cyc;
    chk("ld_bub0", o_reg_we, 0);
    chk("ld_stall1", o_stall_mem, 1);
    cyc;
    chk("ld_bub1", o_reg_we, 0);
    chk("ld_stall2", o_stall_mem, 1);
    cyc;
    chk("ld_bub2", o_reg_we, 0);
    chk("ld_bub2_alu", o_alu_result, 0);
    i_dc_ack   = 1'b1;
    i_dc_rdata = 64'h8877665544332211;
    #1;
    chk("ld_ack_stall", o_stall_mem, 0);
    cyc;
    chk("ld_data", o_read_data, 64'h8877665544332211);
    chk("ld_we", o_reg_we, 1);
    chk("ld_rd", o_rd_addr, 10);
    chk("ld_src", o_result_src, 1);

    // lb / lbu at 0x1005, same-cycle ack
    mem(64'h1005, 3'd0, 1'b0, 64'h0);
    i_dc_ack   = 1'b1;
    i_dc_rdata = 64'h0000800000000000;
    #2;
    chk("lb_stall", o_stall_mem, 0);
    chk("lb_addr", o_dc_addr, 64'h1000);
    cyc;
    chk("lb_data", o_read_data, 64'hFFFFFFFFFFFFFF80);
    i_func3 = 3'd4;
    cyc;
    chk("lbu_data", o_read_data, 64'h80);

    // sh 0x2002
    mem(64'h2002, 3'd1, 1'b1, 64'hBEEF);
    i_dc_ack = 1'b1;
    #2;
    chk("sh_strb", o_dc_wstrb, 8'h0C);
    chk("sh_wdata", o_dc_wdata, 64'hBEEF0000);
    chk("sh_we", o_dc_we, 1);
    chk("sh_addr", o_dc_addr, 64'h2000);
    cyc;
    chk("sh_rdata", o_read_data, 0);
    chk("sh_regwe", o_reg_we, 0);

    // reset while in WAIT
    mem(64'h1000, 3'd3, 1'b0, 64'h0);
    i_dc_ack = 1'b0;
    cyc;
    chk("rw_stall", o_stall_mem, 1);
    #2;
    i_arst = 1'b1;
    #1;
    chk("rw_req", o_dc_req, 0);
    chk("rw_regwe", o_reg_we, 0);
    chk("rw_rdata", o_read_data, 0);
    chk("rw_pc4", o_pc_plus4, 0);
    cyc;
    i_arst = 1'b0;
    i_dc_ack   = 1'b1;
    i_dc_rdata = 64'h0123456789ABCDEF;
    #1;
    chk("rw_req2", o_dc_req, 1);
    chk("rw_stall2", o_stall_mem, 0);
    cyc;
    chk("rw_data", o_read_data, 64'h0123456789ABCDEF);
    idle_in();
    #1;
    chk("rw_idle", o_stall_mem, 0);

    // misaligned word accesses at 0x3002
    mem(64'h3002, 3'd2, 1'b0, 64'h0);
    i_dc_ack   = 1'b1;
    i_dc_rdata = 64'h112233448899AABB;
    #2;
`ifdef MISALIGN_TRAP_EN
    chk("lw_mis_req", o_dc_req, 0);
    chk("lw_mis_stall", o_stall_mem, 0);
    cyc;
    chk("lw_mis_cause", o_cause, 4);
    chk("lw_mis_we", o_reg_we, 0);
    mem(64'h3002, 3'd2, 1'b1, 64'h12345678);
    #2;
    chk("sw_mis_req", o_dc_req, 0);
    cyc;
    chk("sw_mis_cause", o_cause, 6);
`else
    chk("lw_mis_req", o_dc_req, 1);
    chk("lw_mis_addr", o_dc_addr, 64'h3000);
    cyc;
    chk("lw_mis_data", o_read_data, 64'hFFFFFFFF8899AABB);
    chk("lw_mis_cause", o_cause, 0);
    mem(64'h3002, 3'd2, 1'b1, 64'h12345678);
    #2;
    chk("sw_mis_strb", o_dc_wstrb, 8'h0F);
    chk("sw_mis_wdata", o_dc_wdata, 64'h12345678);
    cyc;
    chk("sw_mis_cause", o_cause, 0);
`endif

    // illegal func3 on load and store
    mem(64'h4000, 3'd7, 1'b0, 64'h0);
    i_dc_ack = 1'b0;
    #2;
    chk("ill_ld_req", o_dc_req, 0);
    chk("ill_ld_stall", o_stall_mem, 0);
    cyc;
    chk("ill_ld_cause", o_cause, 2);
    chk("ill_ld_we", o_reg_we, 0);
    mem(64'h4000, 3'd4, 1'b1, 64'h0);
    #2;
    chk("ill_st_req", o_dc_req, 0);
    cyc;
    chk("ill_st_cause", o_cause, 2);

    // incoming exception suppresses the access
    mem(64'h5000, 3'd3, 1'b0, 64'h0);
    i_cause = 4'd5;
    #2;
    chk("exc_req", o_dc_req, 0);
    chk("exc_stall", o_stall_mem, 0);
    cyc;
    chk("exc_cause", o_cause, 5);
    chk("exc_we", o_reg_we, 0);
    chk("exc_alu", o_alu_result, 64'h5000);

    // stray ack with no request
    idle_in();
    i_dc_ack     = 1'b1;
    i_reg_we     = 1'b1;
    i_alu_result = 64'h55;
    #2;
    chk("stray_req", o_dc_req, 0);
    chk("stray_stall", o_stall_mem, 0);
    cyc;
    chk("stray_we", o_reg_we, 1);
    chk("stray_alu", o_alu_result, 64'h55);
    chk("stray_rdata", o_read_data, 0);
    i_dc_ack = 1'b0;
    #1;
    chk("stray_idle", o_stall_mem, 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
